// File: rtl/audio_pkg.sv
// Shared audio definitions: frame geometry,
// sample type and the I2S slot bit selector.
package audio_pkg;

  localparam int SLOT_BITS   = 32;
  localparam int FRAME_SLOTS = 64;
  localparam int SAMPLE_W    = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Bit carried by slot k of a half frame.
  // Slot 0 is the one-bit delay, slots
  // 1..dw carry the word MSB first, the
  // rest pad with zero.
  function automatic logic slot_bit(
    input logic [SLOT_BITS-1:0] word,
    input int                   dw,
    input logic [4:0]           k
  );
    logic       b;
    logic [4:0] idx;
    b   = 1'b0;
    idx = 5'(dw - int'(k));
    if (k != 5'd0 && int'(k) <= dw)
      b = word[idx];
    return b;
  endfunction

endpackage

// File: rtl/audio_clkdiv.sv
// Modulo-DIV counter with a registered
// half-duty output, high for the upper half.
module audio_clkdiv #(
  parameter int DIV = 16,
  parameter int CW  = $clog2(DIV)
) (
  input  logic          clock,
  input  logic          reset,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          half
);

  logic [CW-1:0] count_next;

  assign wrap = (count == CW'(DIV-1));

  // Next count value, wrapping to zero.
  always_comb begin
    count_next = count + CW'(1);
    if (wrap)
      count_next = '0;
  end

  // Count and half-duty output track together.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      half  <= 1'b0;
    end else begin
      count <= count_next;
      half  <= (count_next >= CW'(DIV/2));
    end
  end

endmodule

// File: rtl/i2s_tx_frame.sv
// Stereo I2S transmitter: 64-slot frame,
// samples latched once per frame.
module i2s_tx_frame
  import audio_pkg::*;
#(
  parameter int DW      = 16,
  parameter int SCK_DIV = 16,
  parameter int MCK_DIV = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW-1:0] ldata,
  input  logic [DW-1:0] rdata,
  input  logic          mute,
  output logic          sampled,
  output logic          mck,
  output logic          sck,
  output logic          lr,
  output logic          d
);

  localparam int SW  = $clog2(FRAME_SLOTS);
  localparam int DVW = $clog2(SCK_DIV);
  localparam int MW  = $clog2(MCK_DIV);

  logic [DVW-1:0] div;
  logic           div_wrap;
  logic [MW-1:0]  mdiv;
  logic           mdiv_wrap;
  logic           unused_mck;

  logic [SW-1:0]  s;
  logic [SW-1:0]  s_next;
  logic [DW-1:0]  hold_l;
  logic [DW-1:0]  hold_r;
  logic           load;
  logic           right;
  logic           bit_next;
  logic [SLOT_BITS-1:0] word;

  audio_clkdiv #(
    .DIV (SCK_DIV),
    .CW  (DVW)
  ) u_sck (
    .clock (clock),
    .reset (reset),
    .count (div),
    .wrap  (div_wrap),
    .half  (sck)
  );

  audio_clkdiv #(
    .DIV (MCK_DIV),
    .CW  (MW)
  ) u_mck (
    .clock (clock),
    .reset (reset),
    .count (mdiv),
    .wrap  (mdiv_wrap),
    .half  (mck)
  );

  assign unused_mck = ^{mdiv, mdiv_wrap};

  // Slot advance, load strobe and the bit
  // that the next slot will carry.
  always_comb begin
    s_next = s;
    if (div_wrap)
      s_next = s + SW'(1);
    load  = div_wrap && (s == SW'(FRAME_SLOTS-1));
    right = s_next[SW-1];
    word  = right ? SLOT_BITS'(hold_r)
                  : SLOT_BITS'(hold_l);
    bit_next = slot_bit(word, DW,
                        s_next[SW-2:0]);
  end

  // Slot counter, sample holds and serial
  // outputs, all stepping on the sck fall.
  always_ff @(posedge clock) begin
    if (reset) begin
      s       <= '0;
      hold_l  <= '0;
      hold_r  <= '0;
      sampled <= 1'b0;
      lr      <= 1'b0;
      d       <= 1'b0;
    end else begin
      s       <= s_next;
      sampled <= load;
      if (load) begin
        hold_l <= mute ? '0 : ldata;
        hold_r <= mute ? '0 : rdata;
      end
      if (div_wrap) begin
        lr <= right;
        d  <= bit_next;
      end
    end
  end

endmodule

// File: doc/i2s_tx_frame.md
# i2s_tx_frame

Stereo I2S serializer between the machine's audio mixer outputs and the board audio codec's serial input. It consumes two parallel signed PCM words, latches them once per frame, and generates master clock, bit clock, word select and serial data from the single system clock. Every output is registered and phase-locked to a free-running divider, so serial timing is exact to the clock cycle.

## Interface
- `DW`, 16: sample width in bits, 1..31.
- `SCK_DIV`, 16: system clocks per bit-clock period; even, ≥4.
- `MCK_DIV`, 4: system clocks per master-clock period; even, ≥2.

Ports:
- `clock`  in  1  system clock (56 MHz nominal).
- `reset`  in  1  synchronous, active-high reset.
- `ldata`  in  DW  left sample, two's complement.
- `rdata`  in  DW  right sample, two's complement.
- `mute`  in  1  when high at load time, zeros are latched instead of the samples.
- `sampled`  out  1  one-cycle pulse: samples were latched this frame.
- `mck`  out  1  master clock, clock/MCK_DIV.
- `sck`  out  1  bit clock, clock/SCK_DIV.
- `lr`  out  1  word select: 0 = left, 1 = right.
- `d`  out  1  serial data, MSB first.

## Operation
- Frame: 64 SCK slots, numbered s = 0..63. Slots 0..31 are left (`lr`=0) and slots 32..63 are right (`lr`=1).
- Standard I2S one-bit delay:
  - slot 0 carries 0;
  - slots 1..DW carry `hold_l[DW-1]`..`hold_l[0]`;
  - slots DW+1..31 carry 0.
  - The right half is the same pattern offset by 32.
- Counters:
  - `div` runs 0..SCK_DIV-1 and wraps.
  - `s` increments when `div` wraps, 63→0.
  - `mdiv` runs 0..MCK_DIV-1 independently.
- Load:
  - On the edge where (s, div) goes from (63, SCK_DIV-1) to (0, 0), `hold_l`/`hold_r` capture `ldata`/`rdata`, or 0 if `mute`=1.
  - `sampled` is high for exactly the following cycle.
- Inputs are sampled only at the load edge. Changes at any other time have no effect on the current frame.
- Reset (any cycle, including mid-frame):
  - div=s=mdiv=0, holds=0.
  - `sck`=`mck`=`lr`=`d`=`sampled`=0.
  - The first frame after reset is transmitted as all zeros.
  - The first load occurs at the end of that first frame.

## Timing
- `sck` = 1 while div ≥ SCK_DIV/2, else 0. It is registered and falls on the edge where div returns to 0.
- `lr` and `d` update only on the edge where div wraps to 0, i.e. coincident with the `sck` falling edge. They hold stable for a full SCK period, so the codec samples them mid-period on `sck` rising.
- `mck` = 1 while mdiv ≥ MCK_DIV/2. It is registered and free-running from reset.
- Frame length = 64·SCK_DIV clocks; with the defaults, 1024 clocks, fs = 54 687.5 Hz.
- Sample latency: from the load edge, the left MSB appears after 1·SCK_DIV clocks and the right MSB after 33·SCK_DIV clocks.
- A `reset` asserted during a frame aborts it immediately. No partial word is completed.

## Structure
- Shared package `audio_pkg` holds `SLOT_BITS`=32, `FRAME_SLOTS`=64, and the `sample_t` typedef (signed [DW-1:0]).
- One natural sub-module: `audio_clkdiv`, a parameterised modulo counter with registered half-duty output.
  - It is instantiated twice, for `sck` (also exporting `div` and its wrap flag) and for `mck`.
- The slot counter, hold registers and bit mux stay in the top of this block.

## Test plan
- Reset, then run 1024 clocks with ldata=16'h1234 → `d` all zeros in frame 0; `sampled` pulses once at clock 1024; `lr` high for exactly 512 clocks.
- ldata=16'hA5C3, rdata=16'h8001 held, defaults → frame 1:
  - slots 1..16 of `d` = 1010_0101_1100_0011;
  - slots 33..48 = 1000_0000_0000_0001;
  - all other slots 0.
- Input toggled every cycle except at the load edge → the serialized word equals the value present at the load edge only.
- `mute`=1 at the load edge with ldata=rdata=16'hFFFF → the whole next frame `d`=0, `sampled` still pulses.
- Clock counts → `sck` period 16 clocks with high time 8; `mck` period 4 clocks with high time 2; `lr`/`d` transitions only on `sck` falling edges.
- `reset` for 1 cycle in slot 20 → the next cycle has all outputs 0 and s=0; a full zero frame follows, then the first `sampled` pulse 1024 clocks after reset.
